fb_uart_readback: RTL and testbench
===================================

// Module: fb_uart_readback
// PURPOSE
//  Reads the 128x32 frame buffer back through the RAM read port and streams it to
//  uart_tx as a byte stream. Outputs the same x-major / y-minor pixel order and the
//  same (x,y)->address mapping that the UART/SPI write path uses to store pixels.
//  Shares rd_clk and the read port with the led_matrix scan-out, via an
//  arbiter/mux in top. Used for host-side verification of frame buffer contents.
// PARAMETERS
//  FB_ADDR_WIDTH  13     frame buffer address width
//  DATA_WIDTH     8      pixel width, and also the UART byte width
//  FB_WIDTH       128    pixels per row (x), x counter 7 bits
//  FB_HEIGHT      32     rows (y), y counter 5 bits
//  PANEL_STRIDE   384    address step per x[3:0]
//  COL_STRIDE     48     address step per x[7:4]
//  HDR0, HDR1     8'hA5, 8'h5A   sync header bytes sent before pixel data
// PORTS
//  rd_clk     in   1              clock (RAM read domain)
//  reset      in   1              synchronous, active-high
//  start      in   1              single-cycle request to dump one frame
//  tx_ready   in   1              uart_tx can accept a byte
//  rd_data    in   DATA_WIDTH     RAM read data, registered one cycle after rd_addr
//  rd_addr    out  FB_ADDR_WIDTH  RAM read address (registered)
//  tx_data    out  DATA_WIDTH     byte to transmit
//  tx_strobe  out  1              one-cycle pulse that transfers tx_data
//  busy       out  1              high from accepted start until done
//  done       out  1              one-cycle pulse after the last byte's strobe
// BEHAVIOUR
//  Reset: rd_addr=0, tx_data=0, tx_strobe=0, busy=0, done=0, x=0, y=0, state=IDLE.
//    Reset mid-frame aborts at once. No further strobes. Next start begins at HDR0.
//  Address map: addr = x[3:0]*PANEL_STRIDE + x[7:4]*COL_STRIDE + (y<16 ? 32+y : y).
//    Compute at FB_ADDR_WIDTH bits. Maximum address is 6127, so no overflow.
//  Pixel order: y increments fastest (0..31), then x (0..127).
//    Total bytes per frame = 2 + 4096 = 4098.
//  FSM:
//    IDLE    start=1 -> HDR. busy<=1, x<=0, y<=0, hdr_idx<=0.
//    HDR     tx_data<=HDRn -> SEND.
//    FETCH   rd_addr<=map(x,y) -> WAIT.
//    WAIT    RAM captures rd_addr -> LOAD.
//    LOAD    tx_data<=rd_data -> SEND.
//    SEND    tx_strobe<=1 only in a cycle where tx_ready=1 -> GAP.
//            Otherwise hold. tx_data stays stable while waiting.
//    GAP     one cycle with tx_ready ignored. uart_tx drops ready within 1 cycle.
//            After header byte 0 -> HDR. After header byte 1 -> FETCH.
//            After a pixel: y==31 && x==127 -> DONE.
//            Else advance y, wrapping to 0 and incrementing x, then -> FETCH.
//    DONE    done<=1 for one cycle, busy<=0 -> IDLE.
//  tx_strobe is high for exactly one cycle per byte and never two cycles in a row.
//  start is ignored while busy (no restart, no queueing).
//  Simultaneous start and reset: reset wins.
//  Minimum pixel period is 5 cycles (FETCH, WAIT, LOAD, SEND, GAP) with tx_ready=1.
//  No combinational path from any input to any output. All outputs are registered.
// STRUCTURE
//  Shared include fb_geometry.vh holds FB_WIDTH, FB_HEIGHT, PANEL_STRIDE,
//    COL_STRIDE, HDR0/HDR1 and the y<16 offset of 32.
//  One sub-module, fb_addr_map: combinational (x,y)->addr.
//    The write path in top also instantiates it so both directions share one mapping.
//  The FSM and counters live in this module.
// TESTING
//  RAM model: mem[a] = a[7:0]. Registered read. Assert start for 1 cycle, tx_ready=1.
//  1 Full dump -> 4098 strobes. Bytes 0,1 = A5,5A.
//    (x0,y0)=mem[32]=0x20. (x0,y16)=mem[16]=0x10.
//    (x1,y0)=mem[416]=0xA0. (x16,y0)=mem[80]=0x50.
//  2 Last pixel (x127,y31) -> rd_addr=6127, byte 0xEF.
//    done pulses 1 cycle after that strobe. busy=0 in the same cycle.
//  3 Hold tx_ready=0 for 100 cycles mid-frame -> no strobe.
//    tx_data and rd_addr stay constant. Stream resumes with the correct next byte.
//  4 Pulse start at byte 500 -> ignored. Total still 4098 bytes with no duplicates.
//  5 Assert reset at byte 1000 -> all outputs at reset values next cycle, no strobe.
//    A new start emits A5,5A,0x20 first.
//  6 tx_ready held at 1 throughout -> strobes spaced exactly 5 cycles apart during pixels.

Source files
------------

// File: rtl/fb_uart_readback_pkg.sv
// rtl/fb_uart_readback_pkg.sv - frame buffer geometry, header bytes and readback FSM types
package fb_uart_readback_pkg;

    localparam int FB_ADDR_W    = 13;
    localparam int PIX_W        = 8;
    localparam int FB_WIDTH     = 128;
    localparam int FB_HEIGHT    = 32;
    localparam int X_W          = 7;
    localparam int Y_W          = 5;
    localparam int PANEL_STRIDE = 384;
    localparam int COL_STRIDE   = 48;
    localparam int Y_LOW_OFFSET = 32;
    localparam int Y_SPLIT      = 16;

    localparam logic [7:0] HDR0 = 8'hA5;
    localparam logic [7:0] HDR1 = 8'h5A;

    localparam logic [X_W-1:0] X_LAST = X_W'(FB_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FB_HEIGHT - 1);

    typedef enum logic [2:0] {
        RB_IDLE,
        RB_HDR,
        RB_FETCH,
        RB_WAIT,
        RB_LOAD,
        RB_SEND,
        RB_GAP,
        RB_DONE
    } rb_state_t;

    // Which byte class the current SEND/GAP pair belongs to.
    typedef enum logic [1:0] {
        PH_HDR0,
        PH_HDR1,
        PH_PIXEL
    } rb_phase_t;

endpackage

// File: rtl/fb_addr_map.sv
// rtl/fb_addr_map.sv - combinational (x,y) to frame buffer address, shared by write and readback paths
module fb_addr_map
    import fb_uart_readback_pkg::*;
#(
    parameter int FB_ADDR_WIDTH = FB_ADDR_W
) (
    input  logic [X_W-1:0]           x,
    input  logic [Y_W-1:0]           y,
    output logic [FB_ADDR_WIDTH-1:0] addr
);

    logic [FB_ADDR_WIDTH-1:0] panel_off;
    logic [FB_ADDR_WIDTH-1:0] col_off;
    logic [FB_ADDR_WIDTH-1:0] row_off;

    // Top half of the rows sits after the bottom half inside each column block.
    always_comb begin
        panel_off = FB_ADDR_WIDTH'(x[3:0]) * FB_ADDR_WIDTH'(PANEL_STRIDE);
        col_off   = FB_ADDR_WIDTH'(x[6:4]) * FB_ADDR_WIDTH'(COL_STRIDE);
        if (y < Y_W'(Y_SPLIT)) begin
            row_off = FB_ADDR_WIDTH'(Y_LOW_OFFSET) + FB_ADDR_WIDTH'(y);
        end else begin
            row_off = FB_ADDR_WIDTH'(y);
        end
        addr = panel_off + col_off + row_off;
    end

endmodule

// File: rtl/fb_uart_readback.sv
// rtl/fb_uart_readback.sv - streams the frame buffer, prefixed by a two-byte sync header, to uart_tx
module fb_uart_readback
    import fb_uart_readback_pkg::*;
#(
    parameter int FB_ADDR_WIDTH = FB_ADDR_W,
    parameter int DATA_WIDTH    = PIX_W
) (
    input  logic                     rd_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     tx_ready,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic [FB_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_strobe,
    output logic                     busy,
    output logic                     done
);

    rb_state_t                state, state_n;
    rb_phase_t                phase, phase_n;
    logic [X_W-1:0]           x, x_n;
    logic [Y_W-1:0]           y, y_n;
    logic [FB_ADDR_WIDTH-1:0] rd_addr_n;
    logic [DATA_WIDTH-1:0]    tx_data_n;
    logic                     tx_strobe_n;
    logic                     busy_n;
    logic                     done_n;
    logic [FB_ADDR_WIDTH-1:0] map_addr;

    fb_addr_map #(
        .FB_ADDR_WIDTH(FB_ADDR_WIDTH)
    ) u_addr_map (
        .x   (x),
        .y   (y),
        .addr(map_addr)
    );

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state     <= RB_IDLE;
            phase     <= PH_HDR0;
            x         <= '0;
            y         <= '0;
            rd_addr   <= '0;
            tx_data   <= '0;
            tx_strobe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            x         <= x_n;
            y         <= y_n;
            rd_addr   <= rd_addr_n;
            tx_data   <= tx_data_n;
            tx_strobe <= tx_strobe_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Outputs are computed alongside the next state so that every port is a flop.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        x_n         = x;
        y_n         = y;
        rd_addr_n   = rd_addr;
        tx_data_n   = tx_data;
        tx_strobe_n = 1'b0;
        busy_n      = busy;
        done_n      = 1'b0;

        case (state)
            RB_IDLE: begin
                if (start) begin
                    state_n = RB_HDR;
                    phase_n = PH_HDR0;
                    busy_n  = 1'b1;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            RB_HDR: begin
                tx_data_n = (phase == PH_HDR0) ? DATA_WIDTH'(HDR0) : DATA_WIDTH'(HDR1);
                state_n   = RB_SEND;
            end
            RB_FETCH: begin
                rd_addr_n = map_addr;
                state_n   = RB_WAIT;
            end
            RB_WAIT: begin
                state_n = RB_LOAD;
            end
            RB_LOAD: begin
                tx_data_n = rd_data;
                state_n   = RB_SEND;
            end
            RB_SEND: begin
                if (tx_ready) begin
                    tx_strobe_n = 1'b1;
                    state_n     = RB_GAP;
                end
            end
            RB_GAP: begin
                // tx_ready is not looked at here: uart_tx needs a cycle to drop it.
                case (phase)
                    PH_HDR0: begin
                        phase_n = PH_HDR1;
                        state_n = RB_HDR;
                    end
                    PH_HDR1: begin
                        phase_n = PH_PIXEL;
                        state_n = RB_FETCH;
                    end
                    default: begin
                        if (x == X_LAST && y == Y_LAST) begin
                            state_n = RB_DONE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                        end else begin
                            state_n = RB_FETCH;
                            if (y == Y_LAST) begin
                                y_n = '0;
                                x_n = x + 7'd1;
                            end else begin
                                y_n = y + 5'd1;
                            end
                        end
                    end
                endcase
            end
            RB_DONE: begin
                state_n = RB_IDLE;
            end
            default: begin
                state_n = RB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fb_uart_readback.sv
// tb/tb_fb_uart_readback.sv - self-checking bench for fb_uart_readback
module tb_fb_uart_readback;

    logic        rd_clk = 1'b0;
    logic        reset;
    logic        start;
    logic        tx_ready;
    logic [7:0]  rd_data;
    logic [12:0] rd_addr;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    fb_uart_readback dut (
        .rd_clk   (rd_clk),
        .reset    (reset),
        .start    (start),
        .tx_ready (tx_ready),
        .rd_data  (rd_data),
        .rd_addr  (rd_addr),
        .tx_data  (tx_data),
        .tx_strobe(tx_strobe),
        .busy     (busy),
        .done     (done)
    );

    always #5 rd_clk = ~rd_clk;

    // RAM model: each location holds the low byte of its own address.
    always @(posedge rd_clk) rd_data <= rd_addr[7:0];

    logic [7:0] cap_data [0:16383];
    int         cap_cyc  [0:16383];
    int         n_cap = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       done_busy = 1'b0;
    int         b2b_cnt = 0;
    logic       prev_strobe = 1'b0;

    always @(negedge rd_clk) begin
        cyc = cyc + 1;
        if (tx_strobe === 1'b1) begin
            if (n_cap < 16384) begin
                cap_data[n_cap] = tx_data;
                cap_cyc[n_cap]  = cyc;
            end
            n_cap = n_cap + 1;
            if (prev_strobe) b2b_cnt = b2b_cnt + 1;
        end
        if (done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
        prev_strobe = (tx_strobe === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        int p, px, py, a;
        if (i == 0) return 8'hA5;
        if (i == 1) return 8'h5A;
        p  = i - 2;
        px = p / 32;
        py = p % 32;
        a  = (px % 16) * 384 + (px / 16) * 48 + ((py < 16) ? 32 + py : py);
        return a[7:0];
    endfunction

    task automatic wait_bytes(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_cap < target && k < budget) begin
            @(negedge rd_clk);
            k++;
        end
        check(name, n_cap, target);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge rd_clk);
            k++;
        end
        check(name, done_cnt, target);
    endtask

    task automatic frame_check(input int base, input string name);
        int bad, first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < 4098; i++) begin
            if (cap_data[base + i] !== exp_byte(i)) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        if (first >= 0)
            $display("first differing byte index %0d: 0x%0h vs 0x%0h", first,
                     cap_data[base + first], exp_byte(first));
        check(name, bad, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge rd_clk);
        start = 1'b0;
    endtask

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int base, dbase, bad_gap, snap_cap;
        logic [7:0]  snap_data;
        logic [12:0] snap_addr;
        int drift;

        vecs[0] = '{0,    8'hA5};
        vecs[1] = '{1,    8'h5A};
        vecs[2] = '{2,    8'h20};
        vecs[3] = '{17,   8'h2F};
        vecs[4] = '{18,   8'h10};
        vecs[5] = '{34,   8'hA0};
        vecs[6] = '{97,   8'h1F};
        vecs[7] = '{514,  8'h50};
        vecs[8] = '{4096, 8'hEE};
        vecs[9] = '{4097, 8'hEF};

        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge rd_clk);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_strobe", tx_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge rd_clk);

        // Full frame with tx_ready held high.
        base  = n_cap;
        dbase = done_cnt;
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_done(dbase + 1, 30000, "f1_done_seen");
        repeat (3) @(negedge rd_clk);
        check("f1_byte_count", n_cap - base, 4098);
        for (int i = 0; i < 10; i++)
            check($sformatf("f1_byte%0d", vecs[i].idx), cap_data[base + vecs[i].idx], vecs[i].exp);
        frame_check(base, "f1_frame");
        check("f1_last_rd_addr", rd_addr, 6127);
        check("f1_done_after_strobe", done_cyc - cap_cyc[base + 4097], 1);
        check("f1_busy_at_done", done_busy, 0);
        check("f1_done_count", done_cnt - dbase, 1);
        check("f1_hdr_spacing", cap_cyc[base + 1] - cap_cyc[base], 3);
        bad_gap = 0;
        for (int i = 3; i < 4098; i++)
            if (cap_cyc[base + i] - cap_cyc[base + i - 1] != 5) bad_gap++;
        check("f1_pixel_spacing", bad_gap, 0);
        check("f1_no_back_to_back", b2b_cnt, 0);

        // Ignored restart at byte 500, then backpressure at byte 2000.
        base  = n_cap;
        dbase = done_cnt;
        pulse_start();
        wait_bytes(base + 500, 5000, "f2_reach_500");
        pulse_start();
        wait_bytes(base + 2000, 10000, "f2_reach_2000");
        tx_ready = 1'b0;
        repeat (8) @(negedge rd_clk);
        snap_cap  = n_cap;
        snap_data = tx_data;
        snap_addr = rd_addr;
        drift     = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge rd_clk);
            if (tx_data !== snap_data || rd_addr !== snap_addr) drift++;
        end
        check("f2_hold_no_strobe", n_cap, snap_cap);
        check("f2_hold_stable", drift, 0);
        check("f2_hold_next_byte", snap_data, exp_byte(snap_cap - base));
        tx_ready = 1'b1;
        wait_done(dbase + 1, 30000, "f2_done_seen");
        repeat (3) @(negedge rd_clk);
        check("f2_byte_count", n_cap - base, 4098);
        check("f2_done_count", done_cnt - dbase, 1);
        frame_check(base, "f2_frame");
        check("f2_no_back_to_back", b2b_cnt, 0);

        // Reset at byte 1000 with start raised in the same cycle.
        base = n_cap;
        pulse_start();
        wait_bytes(base + 1000, 8000, "f3_reach_1000");
        reset = 1'b1;
        start = 1'b1;
        snap_cap = n_cap;
        @(negedge rd_clk);
        check("f3_rst_rd_addr", rd_addr, 0);
        check("f3_rst_tx_data", tx_data, 0);
        check("f3_rst_tx_strobe", tx_strobe, 0);
        check("f3_rst_busy", busy, 0);
        check("f3_rst_done", done, 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge rd_clk);
        check("f3_no_strobe_after_reset", n_cap, snap_cap);
        check("f3_stays_idle", busy, 0);
        base = n_cap;
        pulse_start();
        wait_bytes(base + 3, 100, "f3_restart_bytes");
        check("f3_restart_b0", cap_data[base], 8'hA5);
        check("f3_restart_b1", cap_data[base + 1], 8'h5A);
        check("f3_restart_b2", cap_data[base + 2], 8'h20);
        reset = 1'b1;
        repeat (2) @(negedge rd_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
